// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC DRP arbiter and its requesters.
//   - FSM state encoding of the arbiter
//   - DRP address/data widths and the payload struct latched on grant
//   - XADC register addresses that requesters commonly poll
package xadc_pkg;

  localparam int unsigned DrpAddrW = 7;
  localparam int unsigned DrpDataW = 16;

  typedef logic [DrpAddrW-1:0] drp_addr_t;
  typedef logic [DrpDataW-1:0] drp_data_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } drp_state_e;

  // Payload captured from the granted requester.
  typedef struct packed {
    drp_addr_t addr;
    logic      we;
    drp_data_t wdata;
  } drp_req_t;

  // XADC status registers (read-only measurement results).
  localparam drp_addr_t XadcAddrTemp    = 7'h00;
  localparam drp_addr_t XadcAddrVccint  = 7'h01;
  localparam drp_addr_t XadcAddrVccaux  = 7'h02;
  localparam drp_addr_t XadcAddrVpVn    = 7'h03;
  localparam drp_addr_t XadcAddrVrefp   = 7'h04;
  localparam drp_addr_t XadcAddrVrefn   = 7'h05;
  localparam drp_addr_t XadcAddrVccbram = 7'h06;
  localparam drp_addr_t XadcAddrVaux0   = 7'h10;
  localparam drp_addr_t XadcAddrFlag    = 7'h3F;
  // Configuration register 2 (clock divider / power-down).
  localparam drp_addr_t XadcAddrCfg2    = 7'h42;

endpackage

// File: rtl/xadc_drp_arbiter.sv
// Two-requester round-robin arbiter in front of the XADC DRP port.
//
// One DRP transaction is outstanding at a time: IDLE grants and latches a
// request, ISSUE pulses DEN, WAIT waits for DRDY (or a timeout), RESP pulses
// the grantee's rsp_valid and returns to IDLE.
//
// Ports:
//   clk, rst                  DRP clock, asynchronous active-high reset
//   reqN_valid/ready          request handshake (ready is a one-cycle accept)
//   reqN_addr/we/wdata        request payload, held stable until ready
//   rspN_valid/data/err       completion pulse; data/err hold until next RESP
//   DADDR/DEN/DWE/DI/DO/DRDY  XADC DRP interface
//   busy                      high whenever the FSM is not idle
module xadc_drp_arbiter
  import xadc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DrpAddrW-1:0] req0_addr,
  input  logic                req0_we,
  input  logic [DrpDataW-1:0] req0_wdata,

  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DrpAddrW-1:0] req1_addr,
  input  logic                req1_we,
  input  logic [DrpDataW-1:0] req1_wdata,

  output logic                rsp0_valid,
  output logic [DrpDataW-1:0] rsp0_data,
  output logic                rsp0_err,

  output logic                rsp1_valid,
  output logic [DrpDataW-1:0] rsp1_data,
  output logic                rsp1_err,

  output logic [DrpAddrW-1:0] DADDR,
  output logic                DEN,
  output logic                DWE,
  output logic [DrpDataW-1:0] DI,
  input  logic [DrpDataW-1:0] DO,
  input  logic                DRDY,

  output logic                busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  // The counter starts at 0 in the first WAIT cycle, so the cycle in which it
  // steps to TIMEOUT_CYCLES is the last WAIT cycle: RESP then lands exactly
  // TIMEOUT_CYCLES cycles after WAIT was entered.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  drp_state_e state_q, state_d;

  drp_req_t        pay_q, pay_d;
  logic            grantee_q, grantee_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [DrpDataW-1:0] rsp0_data_q, rsp0_data_d;
  logic [DrpDataW-1:0] rsp1_data_q, rsp1_data_d;
  logic                rsp0_err_q, rsp0_err_d;
  logic                rsp1_err_q, rsp1_err_d;

  logic any_req;
  logic grant_id;
  logic timeout;
  logic wait_done;

  // Round-robin: on contention the requester not granted last wins.
  assign any_req   = req0_valid | req1_valid;
  assign grant_id  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign timeout   = (cnt_q == CntLast);
  // DRDY takes priority over a coincident timeout.
  assign wait_done = DRDY | timeout;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (wait_done) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    DEN        = 1'b0;
    DADDR      = '0;
    DWE        = 1'b0;
    DI         = '0;
    busy       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Gate with rst: state is already IDLE during reset, but ready must
        // stay low while reset is held.
        req0_ready = !rst && any_req && !grant_id;
        req1_ready = !rst && any_req &&  grant_id;
      end
      StIssue: begin
        busy  = 1'b1;
        DEN   = 1'b1;
        DADDR = pay_q.addr;
        DWE   = pay_q.we;
        DI    = pay_q.wdata;
      end
      StWait: begin
        busy  = 1'b1;
        DADDR = pay_q.addr;
        DWE   = pay_q.we;
        DI    = pay_q.wdata;
      end
      StResp: begin
        busy       = 1'b1;
        DADDR      = pay_q.addr;
        DWE        = pay_q.we;
        DI         = pay_q.wdata;
        rsp0_valid = !grantee_q;
        rsp1_valid =  grantee_q;
      end
      default: ;
    endcase
  end

  assign rsp0_data = rsp0_data_q;
  assign rsp1_data = rsp1_data_q;
  assign rsp0_err  = rsp0_err_q;
  assign rsp1_err  = rsp1_err_q;

  // Datapath next-state: grant latch, timeout counter, response capture.
  always_comb begin
    pay_d       = pay_q;
    grantee_d   = grantee_q;
    last_d      = last_q;
    cnt_d       = '0;
    rsp0_data_d = rsp0_data_q;
    rsp1_data_d = rsp1_data_q;
    rsp0_err_d  = rsp0_err_q;
    rsp1_err_d  = rsp1_err_q;

    if (state_q == StIdle && any_req) begin
      grantee_d = grant_id;
      last_d    = grant_id;
      pay_d     = grant_id ? '{addr: req1_addr, we: req1_we, wdata: req1_wdata}
                           : '{addr: req0_addr, we: req0_we, wdata: req0_wdata};
    end

    if (state_q == StWait) begin
      cnt_d = cnt_q + CntW'(1);
      if (wait_done) begin
        if (!grantee_q) begin
          rsp0_data_d = (DRDY && !pay_q.we) ? DO : '0;
          rsp0_err_d  = !DRDY;
        end else begin
          rsp1_data_d = (DRDY && !pay_q.we) ? DO : '0;
          rsp1_err_d  = !DRDY;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pay_q       <= '0;
      grantee_q   <= 1'b0;
      // Pointing at requester 1 lets requester 0 win the first contention.
      last_q      <= 1'b1;
      cnt_q       <= '0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
      rsp0_err_q  <= 1'b0;
      rsp1_err_q  <= 1'b0;
    end else begin
      pay_q       <= pay_d;
      grantee_q   <= grantee_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
      rsp0_err_q  <= rsp0_err_d;
      rsp1_err_q  <= rsp1_err_d;
    end
  end

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Directed bench for xadc_drp_arbiter. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_xadc_drp_arbiter;
  import xadc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we;
  logic [6:0]  req0_addr;
  logic [15:0] req0_wdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [6:0]  req1_addr;
  logic [15:0] req1_wdata;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [15:0] rsp0_data, rsp1_data;
  logic [6:0]  DADDR;
  logic        DEN, DWE, DRDY, busy;
  logic [15:0] DI, DO;

  int checks = 0;
  int errors = 0;

  xadc_drp_arbiter #(
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_we    (req0_we),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_we    (req1_we),
    .req1_wdata (req1_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .rsp0_err   (rsp0_err),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .rsp1_err   (rsp1_err),
    .DADDR      (DADDR),
    .DEN        (DEN),
    .DWE        (DWE),
    .DI         (DI),
    .DO         (DO),
    .DRDY       (DRDY),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"},
          {23'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
           DEN, DWE, busy}, 32'd0);
    check({tag, "_daddr"}, {25'd0, DADDR}, 32'd0);
    check({tag, "_di"}, {16'd0, DI}, 32'd0);
    check({tag, "_rsp0_data"}, {16'd0, rsp0_data}, 32'd0);
    check({tag, "_rsp1_data"}, {16'd0, rsp1_data}, 32'd0);
  endtask

  logic        exp_g;
  logic        early;
  logic [15:0] exp_other;

  initial begin
    rst        = 1'b0;
    req0_valid = 1'b0; req0_addr = XadcAddrVccint; req0_we = 1'b0; req0_wdata = '0;
    req1_valid = 1'b0; req1_addr = XadcAddrVccaux; req1_we = 1'b0; req1_wdata = '0;
    DRDY       = 1'b0;
    DO         = '0;

    // Reset with both requesters already valid: ready must stay low.
    #1 rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1 check_all_zero("reset");
    cyc(); cyc();
    rst = 1'b0;
    #1;

    // Contention: grants alternate 0,1,0,1 starting with requester 0.
    for (int i = 0; i < 4; i++) begin
      exp_g = 1'(i % 2);
      check("cont_ready", {30'd0, req1_ready, req0_ready}, exp_g ? 32'd2 : 32'd1);
      cyc(); #1;
      check("cont_den", {31'd0, DEN}, 32'd1);
      check("cont_addr", {25'd0, DADDR}, exp_g ? 32'h02 : 32'h01);
      cyc(); cyc();
      DRDY = 1'b1; DO = 16'h1000 + 16'(i);
      cyc();
      DRDY = 1'b0; DO = '0;
      #1;
      check("cont_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, exp_g ? 32'd2 : 32'd1);
      check("cont_rsp_data", {16'd0, exp_g ? rsp1_data : rsp0_data}, 32'h1000 + i);
      exp_other = (i == 0) ? 16'h0000 : 16'h1000 + 16'(i - 1);
      check("cont_other_data", {16'd0, exp_g ? rsp0_data : rsp1_data}, {16'd0, exp_other});
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      cyc(); #1;
    end

    // Single read from requester 0, DRDY three cycles after DEN.
    req0_valid = 1'b1; req0_addr = XadcAddrVaux0; req0_we = 1'b0; req0_wdata = '0;
    #1;
    check("rd_ready", {31'd0, req0_ready}, 32'd1);
    check("rd_busy_idle", {31'd0, busy}, 32'd0);
    cyc(); req0_valid = 1'b0; #1;
    check("rd_den", {29'd0, DEN, DWE, busy}, 32'b101);
    check("rd_daddr", {25'd0, DADDR}, 32'h10);
    cyc(); #1;
    check("rd_den_one_cycle", {31'd0, DEN}, 32'd0);
    check("rd_daddr_hold", {25'd0, DADDR}, 32'h10);
    cyc();
    cyc(); DRDY = 1'b1; DO = 16'h5A5A; #1;
    check("rd_no_early_rsp", {31'd0, rsp0_valid}, 32'd0);
    cyc(); DRDY = 1'b0; DO = '0; #1;
    check("rd_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    check("rd_rsp_data", {16'd0, rsp0_data}, 32'h5A5A);
    check("rd_rsp_err", {31'd0, rsp0_err}, 32'd0);
    cyc(); #1;
    check("rd_after", {29'd0, rsp0_valid, busy, DEN}, 32'd0);
    check("rd_daddr_idle", {25'd0, DADDR}, 32'd0);
    check("rd_data_hold", {16'd0, rsp0_data}, 32'h5A5A);

    // Write from requester 1; DO is non-zero to show writes return 0.
    req1_valid = 1'b1; req1_addr = XadcAddrCfg2; req1_we = 1'b1; req1_wdata = 16'h0400;
    #1;
    check("wr_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
    cyc(); req1_valid = 1'b0; #1;
    check("wr_den_dwe", {30'd0, DEN, DWE}, 32'b11);
    check("wr_daddr", {25'd0, DADDR}, 32'h42);
    check("wr_di", {16'd0, DI}, 32'h0400);
    cyc(); DRDY = 1'b1; DO = 16'hFFFF;
    cyc(); DRDY = 1'b0; DO = '0; #1;
    check("wr_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
    check("wr_rsp_data", {16'd0, rsp1_data}, 32'd0);
    check("wr_rsp_err", {31'd0, rsp1_err}, 32'd0);
    check("wr_other_unchanged", {16'd0, rsp0_data}, 32'h5A5A);
    cyc(); #1;
    req1_we = 1'b0; req1_wdata = '0;

    // Timeout: no DRDY, response exactly 64 cycles after entering WAIT (T+66).
    req0_valid = 1'b1; req0_addr = XadcAddrVpVn;
    #1;
    check("to_ready", {31'd0, req0_ready}, 32'd1);
    cyc(); req0_valid = 1'b0;
    early = 1'b0;
    for (int c = 2; c < 66; c++) begin
      cyc(); #1;
      if (rsp0_valid) early = 1'b1;
    end
    check("to_no_early_rsp", {31'd0, early}, 32'd0);
    cyc(); DRDY = 1'b1; DO = 16'hBEEF; #1;
    check("to_rsp_valid", {31'd0, rsp0_valid}, 32'd1);
    check("to_rsp_err", {31'd0, rsp0_err}, 32'd1);
    check("to_rsp_data", {16'd0, rsp0_data}, 32'd0);
    cyc(); #1;
    check("to_late_drdy", {30'd0, rsp0_valid, busy}, 32'd0);
    check("to_hold", {15'd0, rsp0_err, rsp0_data}, 32'h10000);
    cyc(); DRDY = 1'b0; DO = '0; #1;
    check("to_late_drdy2", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);

    // Boundary: DRDY in the cycle the counter reaches the limit wins.
    req1_valid = 1'b1; req1_addr = XadcAddrVrefp;
    #1;
    check("bd_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
    cyc(); req1_valid = 1'b0;
    for (int c = 2; c < 65; c++) cyc();
    cyc(); DRDY = 1'b1; DO = 16'h1234; #1;
    check("bd_no_early_rsp", {31'd0, rsp1_valid}, 32'd0);
    cyc(); DRDY = 1'b0; DO = '0; #1;
    check("bd_rsp_valid", {31'd0, rsp1_valid}, 32'd1);
    check("bd_rsp_err", {31'd0, rsp1_err}, 32'd0);
    check("bd_rsp_data", {16'd0, rsp1_data}, 32'h1234);
    cyc(); #1;

    // Reset mid-WAIT on a requester-0 read.
    req0_valid = 1'b1; req0_addr = XadcAddrVrefn;
    #1;
    check("rw_ready", {31'd0, req0_ready}, 32'd1);
    cyc(); req0_valid = 1'b0;
    cyc();
    cyc(); #1;
    check("rw_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; DRDY = 1'b1; DO = 16'hAAAA;
    #1 check_all_zero("rst_async");
    cyc(); #1;
    check_all_zero("rst_held");
    cyc();
    rst = 1'b0; DRDY = 1'b0; DO = '0;
    #1;
    check("rw_no_rsp", {29'd0, rsp0_valid, rsp1_valid, busy}, 32'd0);
    cyc(); #1;
    check("rw_no_rsp2", {29'd0, rsp0_valid, rsp1_valid, busy}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rw_first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xadc_drp_arbiter.md
XADC_DRP_ARBITER -- requirements
Module: xadc_drp_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles to wait for DRDY after DEN before the transaction is aborted.
REQ-002 clk  in  1  sole clock; DRP clock of the XADC primitive.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 req0_valid / req1_valid  in  1  requester N has a DRP transaction pending.
REQ-005 req0_ready / req1_ready  out  1  one-cycle accept pulse for requester N.
REQ-006 req0_addr / req1_addr  in  7  DRP register address.
REQ-007 req0_we / req1_we  in  1  1 = write, 0 = read.
REQ-008 req0_wdata / req1_wdata  in  16  write data.
REQ-009 rsp0_valid / rsp1_valid  out  1  one-cycle completion pulse for requester N.
REQ-010 rsp0_data / rsp1_data  out  16  read data; 0 for writes and errors.
REQ-011 rsp0_err / rsp1_err  out  1  completion was a timeout; qualified by rspN_valid.
REQ-012 DADDR  out  7  XADC DRP address.
REQ-013 DEN  out  1  XADC DRP enable.
REQ-014 DWE  out  1  XADC DRP write enable.
REQ-015 DI  out  16  XADC DRP write data.
REQ-016 DO  in  16  XADC DRP read data.
REQ-017 DRDY  in  1  XADC DRP ready.
REQ-018 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP, with at most one DRP transaction outstanding.
REQ-020 In IDLE with any reqN_valid high, the block SHALL grant one requester, pulse its reqN_ready in that cycle, latch its addr/we/wdata, record the grantee and go to ISSUE.
REQ-021 Grant SHALL be round-robin: if both are valid, the requester not granted last wins; if only one is valid, it wins.
REQ-022 Requesters SHALL hold valid and payload stable until ready; a request whose valid drops before ready is not served.
REQ-023 In ISSUE, DEN SHALL be high for exactly one cycle with DADDR, DWE and DI from the latched payload, and the FSM SHALL then go to WAIT.
REQ-024 DADDR, DWE and DI SHALL hold the latched payload from ISSUE through RESP, and SHALL be 0 in IDLE.
REQ-025 In WAIT, a timeout counter of width clog2(TIMEOUT_CYCLES+1) SHALL increment each cycle from 0.
REQ-026 DRDY high in WAIT SHALL capture DO (reads) or 0 (writes), clear the error flag and go to RESP.
REQ-027 If the counter reaches TIMEOUT_CYCLES with DRDY low, the block SHALL set the error flag, set data to 0 and go to RESP.
REQ-028 If DRDY is high in the same cycle the counter reaches TIMEOUT_CYCLES, DRDY SHALL win and no error is flagged.
REQ-029 DRDY outside WAIT SHALL be ignored, including a late DRDY after a timeout.
REQ-030 In RESP, the grantee's rspN_valid SHALL pulse for one cycle with rspN_data and rspN_err, and the FSM SHALL return to IDLE.
REQ-031 rsp data and err outputs SHALL hold their value until the next RESP; the non-grantee's rsp outputs SHALL be unchanged.
REQ-032 Latency: accept at cycle T, DEN at T+1, DRDY at T+1+k (k >= 1), rspN_valid at T+2+k, next accept at T+3+k at the earliest.

Reset
REQ-033 Asserting rst SHALL immediately return the FSM to IDLE and abandon any in-flight transaction with no response.
REQ-034 While rst is asserted, all outputs SHALL be 0 and the timeout counter SHALL be 0.
REQ-035 Reset SHALL set the last-grant pointer to requester 1, so requester 0 wins the first simultaneous request.

Structure
REQ-036 A shared package (xadc_pkg) SHALL hold the FSM state encoding, DRP address width (7), data width (16) and the XADC status register addresses used by requesters.
REQ-037 The block SHALL be a single module with no sub-modules; the round-robin grant logic is inline.

Verification
REQ-038 Single read: req0 reads addr 0x10 and DRDY arrives 3 cycles after DEN with DO=0x5A5A -> one DEN pulse with DADDR=0x10 and DWE=0, then rsp0_valid with data 0x5A5A and err=0 at T+5.
REQ-039 Contention: both requesters are continuously valid after reset -> grants go 0,1,0,1, and each rsp goes only to its grantee.
REQ-040 Write: req1 writes 0x0400 to 0x42 -> DEN with DWE=1 and DI=0x0400, then rsp1 data=0, err=0.
REQ-041 Timeout: DRDY is never asserted and TIMEOUT_CYCLES=64 -> rsp err=1 and data=0 exactly 64 cycles after entering WAIT; a DRDY injected afterwards is ignored.
REQ-042 Boundary: DRDY arrives in the cycle the counter reaches TIMEOUT_CYCLES -> err=0 and DO is returned.
REQ-043 Reset mid-WAIT: rst asserted -> all outputs 0 asynchronously, no rsp pulse, and after release req0 is granted first.
